// File: rtl/wb_guard_pkg.sv
// rtl/wb_guard_pkg.sv - shared encodings for the Wishbone bus guard
package wb_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_UNMAPPED = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } cause_t;

  localparam logic [2:0] CSR_STATUS    = 3'd0;
  localparam logic [2:0] CSR_ERR_ADDR  = 3'd1;
  localparam logic [2:0] CSR_ERR_COUNT = 3'd2;
  localparam logic [2:0] CSR_CTRL      = 3'd3;

endpackage

// File: rtl/wb_bus_guard_if.sv
// rtl/wb_bus_guard_if.sv - upstream and downstream Wishbone signals of the guard
interface wb_bus_guard_if;
  logic        m_cyc_i;
  logic        m_stb_i;
  logic        m_we_i;
  logic [3:0]  m_sel_i;
  logic [31:0] m_adr_i;
  logic [31:0] m_dat_i;
  logic        m_ack_o;
  logic [31:0] m_dat_o;
  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;

  // slave: the guard itself; master: the environment around it
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/wb_guard_csr.sv
// rtl/wb_guard_csr.sv - error log, error counter, CSR read mux and IRQ
module wb_guard_csr
  import wb_guard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        err_valid,
  input  cause_t      err_cause,
  input  logic [31:0] err_addr_in,
  input  logic        csr_wr,
  input  logic [2:0]  csr_off,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        irq
);

  logic        pending;
  cause_t      cause;
  logic [31:0] err_addr;
  logic [7:0]  err_count;
  logic        irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      cause     <= CAUSE_NONE;
      err_addr  <= '0;
      err_count <= '0;
      irq_en    <= 1'b1;
    end else begin
      if (err_valid) begin
        if (err_count != 8'hFF)
          err_count <= err_count + 8'd1;
        // only the first error since the last clear is recorded in detail
        if (!pending) begin
          pending  <= 1'b1;
          cause    <= err_cause;
          err_addr <= err_addr_in;
        end
      end
      if (csr_wr) begin
        case (csr_off)
          CSR_STATUS: begin
            if (csr_wdata[0]) begin
              pending <= 1'b0;
              cause   <= CAUSE_NONE;
            end
          end
          CSR_ERR_COUNT: err_count <= '0;
          CSR_CTRL:      irq_en    <= csr_wdata[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_off)
      CSR_STATUS:    csr_rdata = {29'd0, cause, pending};
      CSR_ERR_ADDR:  csr_rdata = err_addr;
      CSR_ERR_COUNT: csr_rdata = {24'd0, err_count};
      CSR_CTRL:      csr_rdata = {31'd0, irq_en};
      default:       csr_rdata = '0;
    endcase
  end

  assign irq = pending & irq_en;

endmodule

// File: rtl/wb_bus_guard.sv
// rtl/wb_bus_guard.sv - registers Wishbone requests, forwards mapped windows,
// error-terminates unmapped windows and stalled slaves
module wb_bus_guard
  import wb_guard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned NUM_WIN        = 13,
  parameter logic [3:0]  CSR_WIN        = 4'hF,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  wb_bus_guard_if.slave  bus,
  output logic           err_irq_o
);

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] req_adr, req_dat, resp_dat, resp_dat_nxt;
  logic [3:0]  req_sel;
  logic        req_we, load_req;
  logic [9:0]  tmo_cnt, tmo_cnt_nxt;

  logic        err_valid, csr_wr;
  cause_t      err_cause;
  logic [31:0] err_addr, csr_rdata;
  logic [3:0]  win;

  assign win = bus.m_adr_i[19:16];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= ST_IDLE;
      req_adr  <= '0;
      req_dat  <= '0;
      req_sel  <= '0;
      req_we   <= 1'b0;
      tmo_cnt  <= '0;
      resp_dat <= '0;
    end else begin
      state    <= state_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      resp_dat <= resp_dat_nxt;
      if (load_req) begin
        req_adr <= bus.m_adr_i;
        req_dat <= bus.m_dat_i;
        req_sel <= bus.m_sel_i;
        req_we  <= bus.m_we_i;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    load_req     = 1'b0;
    tmo_cnt_nxt  = tmo_cnt;
    resp_dat_nxt = resp_dat;
    err_valid    = 1'b0;
    err_cause    = CAUSE_NONE;
    err_addr     = req_adr;
    csr_wr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.m_cyc_i && bus.m_stb_i) begin
          load_req = 1'b1;
          if (32'(win) < NUM_WIN) begin
            state_nxt   = ST_FWD;
            tmo_cnt_nxt = '0;
          end else if (win == CSR_WIN) begin
            csr_wr       = bus.m_we_i;
            resp_dat_nxt = bus.m_we_i ? 32'd0 : csr_rdata;
            state_nxt    = ST_RESP;
          end else begin
            resp_dat_nxt = ERR_DATA;
            err_valid    = 1'b1;
            err_cause    = CAUSE_UNMAPPED;
            err_addr     = bus.m_adr_i;
            state_nxt    = ST_RESP;
          end
        end
      end
      ST_FWD: begin
        tmo_cnt_nxt = tmo_cnt + 10'd1;
        // an abandoned cycle is dropped silently; a late slave ack still beats the timeout
        if (!bus.m_cyc_i) begin
          state_nxt = ST_IDLE;
        end else if (bus.s_ack_i) begin
          resp_dat_nxt = bus.s_dat_i;
          state_nxt    = ST_RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          resp_dat_nxt = ERR_DATA;
          err_valid    = 1'b1;
          err_cause    = CAUSE_TIMEOUT;
          state_nxt    = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  wb_guard_csr u_csr (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_ni),
    .err_valid   (err_valid),
    .err_cause   (err_cause),
    .err_addr_in (err_addr),
    .csr_wr      (csr_wr),
    .csr_off     (bus.m_adr_i[4:2]),
    .csr_wdata   (bus.m_dat_i),
    .csr_rdata   (csr_rdata),
    .irq         (err_irq_o)
  );

  assign bus.s_cyc_o = (state == ST_FWD);
  assign bus.s_stb_o = (state == ST_FWD);
  assign bus.s_we_o  = req_we;
  assign bus.s_sel_o = req_sel;
  assign bus.s_adr_o = req_adr;
  assign bus.s_dat_o = req_dat;
  assign bus.m_ack_o = (state == ST_RESP);
  assign bus.m_dat_o = resp_dat;

endmodule
